// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Single-outstanding memory access sequencer between the multicycle core
//   and the RAM/UART bus decoder. It latches one request, runs a bus phase
//   with an ack timeout, and returns a one-cycle done pulse with an optional
//   abort flag and the formatted load result.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   req/we/be/addr/wdata  request pulse and its command, sampled in IDLE
//   ld_op                 load format (LW/LH/LHU/LB/LBU, others act as LW)
//   bus_cs/bus_we/bus_be  registered bus command (cs only while in BUS)
//   bus_addr/bus_wdata    word address and lane-replicated store data
//   bus_rdata/bus_ack     word read data and completion
//   done/err/rdata        completion pulse, abort flag, load result
module mem_access_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int AW      = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  input  logic [2:0]    ld_op,
  output logic          bus_cs,
  output logic          bus_we,
  output logic [3:0]    bus_be,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_ack,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic [3:0]      be_q;
  logic [1:0]      alo_q;
  logic [2:0]      op_q;
  logic [AW-1:0]   baddr_q;
  logic [31:0]     bwdata_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic            accept;
  logic            timeout;

  // Store data is placed in the low bits; replicate it so every enabled
  // lane sees the right byte/half regardless of the address offset.
  function automatic logic [31:0] lane_rep(input logic [3:0] b, input logic [31:0] d);
    logic [2:0] pc;
    pc = 3'(b[0]) + 3'(b[1]) + 3'(b[2]) + 3'(b[3]);
    case (pc)
      3'd1:    lane_rep = {4{d[7:0]}};
      3'd2:    lane_rep = {2{d[15:0]}};
      default: lane_rep = d;
    endcase
  endfunction

  function automatic logic [31:0] ld_fmt(input logic [2:0] op, input logic [1:0] a,
                                         input logic [31:0] w);
    logic [7:0]  byt;
    logic [15:0] hlf;
    byt = 8'(w >> {a, 3'b000});
    hlf = a[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   ld_fmt = {{24{byt[7]}}, byt};
      OP_LBU:  ld_fmt = {24'h0, byt};
      OP_LH:   ld_fmt = {{16{hlf[15]}}, hlf};
      OP_LHU:  ld_fmt = {16'h0, hlf};
      default: ld_fmt = w;
    endcase
  endfunction

  assign timeout = (cnt == TMO);

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (req) begin
        accept  = 1'b1;
        // a store with no lanes enabled can never complete on the bus
        state_d = (we && be == 4'b0000) ? DONE : BUS;
      end
      BUS:  if (bus_ack || timeout) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      alo_q    <= 2'b00;
      op_q     <= 3'b000;
      baddr_q  <= '0;
      bwdata_q <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        we_q     <= we;
        be_q     <= be;
        alo_q    <= addr[1:0];
        op_q     <= ld_op;
        baddr_q  <= AW'(addr[31:2]);
        bwdata_q <= lane_rep(be, wdata);
        err_q    <= we && (be == 4'b0000);
      end
      case (state)
        IDLE: cnt <= '0;   // guarantees a fresh count on BUS entry
        BUS: begin
          if (bus_ack) begin
            err_q <= 1'b0;   // ack beats a coincident timeout
            if (!we_q) rdata_q <= ld_fmt(op_q, alo_q, bus_rdata);
          end else if (timeout) begin
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_cs    = (state == BUS);
  assign bus_we    = bus_cs & we_q;
  assign bus_be    = be_q;
  assign bus_addr  = baddr_q;
  assign bus_wdata = bwdata_q;
  assign done      = (state == DONE);
  assign err       = done & err_q;
  assign rdata     = rdata_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles the bus phase waits for bus_ack before aborting.
REQ-002 Parameter AW, default 30: bus word-address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  1  one-cycle access request pulse from the multicycle controller.
REQ-006 we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 be  input  4  byte enables from the byte-enable stage; sampled with req.
REQ-008 addr  input  32  byte address (ALU result); sampled with req.
REQ-009 wdata  input  32  unaligned store source (rt value, data in low bits); sampled with req.
REQ-010 ld_op  input  3  load format: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; other codes SHALL act as LW.
REQ-011 bus_cs / bus_we  output  1 each  bus cycle valid / write strobe.
REQ-012 bus_be  output  4,  bus_addr  output  AW,  bus_wdata  output  32  registered bus command.
REQ-013 bus_rdata  input  32,  bus_ack  input  1  word read data and completion from RAM/UART decoder.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 rdata  output  32  formatted load result.
REQ-016 err  output  1  set with done when the access aborted.

Function
REQ-017 FSM SHALL have states IDLE, BUS, DONE.
REQ-018 IDLE: req=1 SHALL latch we, be, addr, wdata, ld_op and move to BUS; req in BUS or DONE SHALL be ignored (no queueing).
REQ-019 IDLE with req=1, we=1, be=0000: SHALL skip BUS, go to DONE, err=1.
REQ-020 BUS: bus_cs=1, bus_we=latched we, bus_be=latched be (loads drive be as latched), bus_addr=addr[31:2].
REQ-021 bus_wdata SHALL be lane-replicated: be popcount 1 -> {4{wdata[7:0]}}, popcount 2 -> {2{wdata[15:0]}}, else wdata.
REQ-022 BUS with bus_ack=1: load SHALL capture formatted bus_rdata into rdata; state -> DONE, err=0.
REQ-023 BUS without ack: wait counter increments; when counter equals TIMEOUT and no ack, state -> DONE, err=1, rdata unchanged.
REQ-024 Counter SHALL clear on entry to BUS; ack in the same cycle as timeout SHALL win (err=0).
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; bus_cs=0 in IDLE and DONE.
REQ-026 Load formatting by latched addr[1:0]: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1] (addr[0] ignored); LB/LH sign-extend, LBU/LHU zero-extend; LW ignores addr[1:0].
REQ-027 rdata SHALL hold its value until the next successful load; stores and aborted accesses SHALL NOT change it.
REQ-028 Latency with immediate ack: req in cycle N -> bus_cs in N+1 -> done in N+2.
REQ-029 err SHALL be valid only while done=1 and 0 otherwise.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, counter 0, done=0, err=0, bus_cs=0, bus_we=0, bus_be=0000, bus_addr=0, bus_wdata=0, rdata=0.
REQ-031 Reset during BUS SHALL abort the access without done; a bus_ack arriving after deassertion while in IDLE SHALL be ignored.
REQ-032 First req SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-033 SB: addr=0x0000_0103, be=1000, wdata=0x0000_00A5, ack next cycle -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x40, done in N+2, err=0.
REQ-034 LB: addr=0x2, ld_op=011, bus_rdata=0x0080_0000 -> rdata=0xFFFF_FF80; same with LBU -> 0x0000_0080.
REQ-035 LH: addr=0x2, bus_rdata=0x8001_1234 -> rdata=0xFFFF_8001; LW addr=0x4 -> 0x8001_1234.
REQ-036 No ack for TIMEOUT=15 cycles -> done with err=1 on 17th cycle after req, rdata unchanged; ack exactly at cycle 15 -> err=0.
REQ-037 rst_n pulled low during BUS, then ack asserted after release -> no done, bus_cs=0, next req served normally.
REQ-038 req pulsed while in BUS -> ignored; store with be=0000 -> done in N+1, err=1, no bus_cs.
